// File: rtl/cpu_bus_pkg.sv
// Shared types for the 8088 maximum-mode bus-cycle initiator.
// Request kinds, S2..S0 status encodings and FSM states.
package cpu_bus_pkg;

   typedef enum logic [2:0] {
      MEM_RD, MEM_WR, IO_RD, IO_WR, FETCH, INTA, HALT
   } req_t;

   typedef enum logic [2:0] {
      IDLE, T1, T2, T3, TW, T4
   } state_t;

   typedef logic [2:0] status_t;

   localparam status_t STS_INTA    = 3'b000;
   localparam status_t STS_IORD    = 3'b001;
   localparam status_t STS_IOWR    = 3'b010;
   localparam status_t STS_HALT    = 3'b011;
   localparam status_t STS_FETCH   = 3'b100;
   localparam status_t STS_MRD     = 3'b101;
   localparam status_t STS_MWR     = 3'b110;
   localparam status_t STS_PASSIVE = 3'b111;

   function automatic status_t status_of(input req_t t);
      status_t s;
      unique case (t)
         MEM_RD:  s = STS_MRD;
         MEM_WR:  s = STS_MWR;
         IO_RD:   s = STS_IORD;
         IO_WR:   s = STS_IOWR;
         FETCH:   s = STS_FETCH;
         INTA:    s = STS_INTA;
         HALT:    s = STS_HALT;
         default: s = STS_PASSIVE;
      endcase
      return s;
   endfunction

   function automatic logic is_write(input req_t t);
      return (t == MEM_WR) || (t == IO_WR);
   endfunction

   function automatic logic is_io(input req_t t);
      return (t == IO_RD) || (t == IO_WR);
   endfunction

endpackage

// File: rtl/cpu_bus_initiator_timer.sv
// Tw state counter: clears in T1, counts each TW, saturates.
// expired_o flags the TW in which the count reaches TIMEOUT_CYCLES.
module bus_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int unsigned CW =
      (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam int unsigned LIM_I =
      (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CW-1:0] LIM = CW'(LIM_I);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // cnt_q holds the number of completed TW states before this one
   assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q >= LIM);

endmodule

// File: rtl/cpu_bus_initiator.sv
// 8088 maximum-mode bus-cycle initiator: request/response handshake
// in, T1..T4 bus cycles with Tw wait states out.
module cpu_bus_initiator
   import cpu_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  req_t        req_type,
   input  logic [19:0] req_address,
   input  logic [7:0]  req_data,
   output logic        resp_valid,
   output logic [7:0]  resp_data,
   output logic        resp_timeout,
   output logic [19:0] cpu_address,
   output logic [7:0]  cpu_data_bus,
   output logic [2:0]  processor_status,
   output logic        processor_lock_n,
   input  logic        processor_ready,
   input  logic [7:0]  data_bus_in
);

   state_t      state_q;
   req_t        type_q;
   logic [7:0]  data_q;
   logic        inta2_q;
   logic        inta_cont_q;
   logic        req_ready_q;
   logic        resp_valid_q;
   logic [7:0]  resp_data_q;
   logic        resp_timeout_q;
   logic [19:0] addr_q;
   logic [7:0]  dbus_q;
   status_t     status_q;
   logic        lock_n_q;
   logic        tmo_hit;
   logic        accept;

   assign accept = req_valid && req_ready_q;

   bus_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (state_q == T1),
      .inc_i    (state_q == TW),
      .expired_o(tmo_hit)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         type_q         <= MEM_RD;
         data_q         <= '0;
         inta2_q        <= 1'b0;
         inta_cont_q    <= 1'b0;
         req_ready_q    <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_data_q    <= '0;
         resp_timeout_q <= 1'b0;
         addr_q         <= '0;
         dbus_q         <= '0;
         status_q       <= STS_PASSIVE;
         lock_n_q       <= 1'b1;
      end else begin
         resp_valid_q   <= 1'b0;
         resp_timeout_q <= 1'b0;
         unique case (state_q)
            IDLE, T4: begin
               if (inta_cont_q) begin
                  state_q     <= T1;
                  inta2_q     <= 1'b1;
                  inta_cont_q <= 1'b0;
                  status_q    <= STS_INTA;
               end else if (accept) begin
                  state_q     <= T1;
                  req_ready_q <= 1'b0;
                  type_q      <= req_type;
                  data_q      <= req_data;
                  inta2_q     <= 1'b0;
                  status_q    <= status_of(req_type);
                  addr_q      <= is_io(req_type)
                               ? {4'h0, req_address[15:0]}
                               : req_address;
               end else begin
                  state_q     <= IDLE;
                  req_ready_q <= 1'b1;
               end
            end
            T1: begin
               state_q <= T2;
               if (is_write(type_q))
                  dbus_q <= data_q;
               if (type_q == INTA && !inta2_q)
                  lock_n_q <= 1'b0;
            end
            T2: begin
               state_q <= T3;
               if (type_q == INTA && inta2_q)
                  lock_n_q <= 1'b1;
            end
            T3, TW: begin
               if (type_q == HALT || processor_ready ||
                   (state_q == TW && tmo_hit)) begin
                  state_q  <= T4;
                  status_q <= STS_PASSIVE;
                  // first INTA cycle completes silently into the second
                  if (type_q == INTA && !inta2_q && processor_ready) begin
                     inta_cont_q <= 1'b1;
                  end else begin
                     resp_valid_q <= 1'b1;
                     req_ready_q  <= 1'b1;
                     if (type_q == HALT)
                        resp_data_q <= '0;
                     else if (processor_ready)
                        resp_data_q <= is_write(type_q) ? 8'h00 : data_bus_in;
                     else begin
                        resp_data_q    <= 8'hFF;
                        resp_timeout_q <= 1'b1;
                        lock_n_q       <= 1'b1;
                     end
                  end
               end else begin
                  state_q <= TW;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready        = req_ready_q;
   assign resp_valid       = resp_valid_q;
   assign resp_data        = resp_data_q;
   assign resp_timeout     = resp_timeout_q;
   assign cpu_address      = addr_q;
   assign cpu_data_bus     = dbus_q;
   assign processor_status = status_q;
   assign processor_lock_n = lock_n_q;

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Directed bench for cpu_bus_initiator with a response scoreboard.
// DUT built with an 8-state Tw timeout.
module tb_cpu_bus_initiator;
   import cpu_bus_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   req_t        req_type;
   logic [19:0] req_address;
   logic [7:0]  req_data;
   logic        resp_valid;
   logic [7:0]  resp_data;
   logic        resp_timeout;
   logic [19:0] cpu_address;
   logic [7:0]  cpu_data_bus;
   logic [2:0]  processor_status;
   logic        processor_lock_n;
   logic        processor_ready;
   logic [7:0]  data_bus_in;

   int vectors = 0;
   int errs = 0;
   logic [8:0] sb[$];

   always #5 clock = ~clock;

   cpu_bus_initiator #(
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_type        (req_type),
      .req_address     (req_address),
      .req_data        (req_data),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .resp_timeout    (resp_timeout),
      .cpu_address     (cpu_address),
      .cpu_data_bus    (cpu_data_bus),
      .processor_status(processor_status),
      .processor_lock_n(processor_lock_n),
      .processor_ready (processor_ready),
      .data_bus_in     (data_bus_in)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      if (resp_valid === 1'b1) begin
         logic [8:0] e;
         vectors++;
         assert (sb.size() != 0) else begin
            errs++;
            $error("FAIL resp_unexpected observed=1 expected=0");
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_data", 32'(resp_data), 32'(e[7:0]));
            chk("resp_timeout", 32'(resp_timeout), 32'(e[8]));
         end
      end
   end

   initial begin
      int n;
      reset = 1'b1;
      req_valid = 1'b0;
      req_type = MEM_RD;
      req_address = '0;
      req_data = '0;
      processor_ready = 1'b1;
      data_bus_in = '0;
      #12;
      chk("rst_status", 32'(processor_status), 'h7);
      chk("rst_lock", 32'(processor_lock_n), 'h1);
      chk("rst_addr", 32'(cpu_address), 'h0);
      chk("rst_dbus", 32'(cpu_data_bus), 'h0);
      chk("rst_ready", 32'(req_ready), 'h0);
      chk("rst_rvalid", 32'(resp_valid), 'h0);
      chk("rst_rto", 32'(resp_timeout), 'h0);
      #10 reset = 1'b0;
      step();
      chk("idle_ready", 32'(req_ready), 'h1);

      // memory read, zero wait
      req_valid = 1'b1;
      req_type = MEM_RD;
      req_address = 20'h12345;
      data_bus_in = 8'hA5;
      sb.push_back({1'b0, 8'hA5});
      step();
      req_valid = 1'b0;
      chk("mrd_t1_sts", 32'(processor_status), 'h5);
      chk("mrd_t1_addr", 32'(cpu_address), 'h12345);
      chk("mrd_t1_ready", 32'(req_ready), 'h0);
      step();
      chk("mrd_t2_sts", 32'(processor_status), 'h5);
      step();
      chk("mrd_t3_sts", 32'(processor_status), 'h5);
      chk("mrd_t3_rv", 32'(resp_valid), 'h0);
      step();
      chk("mrd_t4_sts", 32'(processor_status), 'h7);
      chk("mrd_t4_rv", 32'(resp_valid), 'h1);
      step();
      chk("mrd_idle_rv", 32'(resp_valid), 'h0);
      chk("mrd_idle_ready", 32'(req_ready), 'h1);

      // IO write with three wait states
      processor_ready = 1'b0;
      req_valid = 1'b1;
      req_type = IO_WR;
      req_address = 20'hA03F8;
      req_data = 8'h5A;
      sb.push_back({1'b0, 8'h00});
      step();
      req_valid = 1'b0;
      chk("iow_t1_sts", 32'(processor_status), 'h2);
      chk("iow_t1_addr", 32'(cpu_address), 'h003F8);
      step();
      chk("iow_t2_dbus", 32'(cpu_data_bus), 'h5A);
      step();
      step();
      chk("iow_tw1_rv", 32'(resp_valid), 'h0);
      step();
      step();
      processor_ready = 1'b1;
      chk("iow_tw3_rv", 32'(resp_valid), 'h0);
      chk("iow_tw3_sts", 32'(processor_status), 'h2);
      step();
      chk("iow_t4_rv", 32'(resp_valid), 'h1);
      chk("iow_t4_sts", 32'(processor_status), 'h7);
      chk("iow_t4_dbus", 32'(cpu_data_bus), 'h5A);
      step();

      // interrupt acknowledge, two locked cycles
      req_valid = 1'b1;
      req_type = INTA;
      req_address = '0;
      data_bus_in = 8'h33;
      sb.push_back({1'b0, 8'h08});
      step();
      req_valid = 1'b0;
      chk("inta_t1a_sts", 32'(processor_status), 'h0);
      chk("inta_t1a_lock", 32'(processor_lock_n), 'h1);
      step();
      chk("inta_t2a_lock", 32'(processor_lock_n), 'h0);
      step();
      step();
      chk("inta_t4a_sts", 32'(processor_status), 'h7);
      chk("inta_t4a_rv", 32'(resp_valid), 'h0);
      chk("inta_t4a_ready", 32'(req_ready), 'h0);
      chk("inta_t4a_lock", 32'(processor_lock_n), 'h0);
      step();
      data_bus_in = 8'h08;
      chk("inta_t1b_sts", 32'(processor_status), 'h0);
      chk("inta_t1b_lock", 32'(processor_lock_n), 'h0);
      step();
      chk("inta_t2b_lock", 32'(processor_lock_n), 'h0);
      step();
      chk("inta_t3b_lock", 32'(processor_lock_n), 'h1);
      step();
      chk("inta_t4b_rv", 32'(resp_valid), 'h1);
      chk("inta_t4b_ready", 32'(req_ready), 'h1);
      step();

      // back-to-back write then fetch
      req_valid = 1'b1;
      req_type = MEM_WR;
      req_address = 20'h00100;
      req_data = 8'hC3;
      sb.push_back({1'b0, 8'h00});
      step();
      chk("b2b_w_sts", 32'(processor_status), 'h6);
      req_type = FETCH;
      req_address = 20'hFFFF0;
      data_bus_in = 8'h90;
      sb.push_back({1'b0, 8'h90});
      step();
      step();
      step();
      chk("b2b_w_t4_rv", 32'(resp_valid), 'h1);
      chk("b2b_w_t4_ready", 32'(req_ready), 'h1);
      chk("b2b_w_t4_dbus", 32'(cpu_data_bus), 'hC3);
      step();
      req_valid = 1'b0;
      chk("b2b_f_t1_sts", 32'(processor_status), 'h4);
      chk("b2b_f_t1_addr", 32'(cpu_address), 'hFFFF0);
      step();
      step();
      step();
      chk("b2b_f_t4_rv", 32'(resp_valid), 'h1);
      chk("b2b_f_t4_sts", 32'(processor_status), 'h7);
      step();

      // timeout after eight wait states
      processor_ready = 1'b0;
      req_valid = 1'b1;
      req_type = MEM_RD;
      req_address = 20'h55555;
      sb.push_back({1'b1, 8'hFF});
      step();
      req_valid = 1'b0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("to_latency", 32'(n), 11);
      chk("to_sts", 32'(processor_status), 'h7);
      chk("to_flag", 32'(resp_timeout), 'h1);
      step();
      chk("to_idle_ready", 32'(req_ready), 'h1);
      chk("to_idle_rv", 32'(resp_valid), 'h0);

      // reset in the middle of a wait state
      req_valid = 1'b1;
      req_type = MEM_RD;
      req_address = 20'h0ABCD;
      step();
      req_valid = 1'b0;
      step();
      step();
      step();
      chk("rstmid_tw_rv", 32'(resp_valid), 'h0);
      reset = 1'b1;
      #1;
      chk("rstmid_sts", 32'(processor_status), 'h7);
      chk("rstmid_lock", 32'(processor_lock_n), 'h1);
      chk("rstmid_ready", 32'(req_ready), 'h0);
      chk("rstmid_addr", 32'(cpu_address), 'h0);
      #1 reset = 1'b0;
      processor_ready = 1'b1;
      step();
      chk("rstmid_idle_ready", 32'(req_ready), 'h1);
      req_valid = 1'b1;
      req_type = IO_RD;
      req_address = 20'hF1234;
      data_bus_in = 8'h7E;
      sb.push_back({1'b0, 8'h7E});
      step();
      req_valid = 1'b0;
      chk("ior_t1_addr", 32'(cpu_address), 'h01234);
      chk("ior_t1_sts", 32'(processor_status), 'h1);
      step();
      step();
      step();
      chk("ior_t4_rv", 32'(resp_valid), 'h1);
      step();

      // halt ignores READY
      processor_ready = 1'b0;
      data_bus_in = 8'hEE;
      req_valid = 1'b1;
      req_type = HALT;
      sb.push_back({1'b0, 8'h00});
      step();
      req_valid = 1'b0;
      chk("halt_t1_sts", 32'(processor_status), 'h3);
      step();
      step();
      step();
      chk("halt_t4_rv", 32'(resp_valid), 'h1);
      step();
      chk("sb_empty", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
